// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   IF-stage direction/target predictor working alongside an external BTB tag table.
//   Lookup (combinational): IF_pc -> IF_btb_index / IF_pht_index, tag compare against
//   corresponding_tag, predict_taken and predicted_pc.
//   Update (posedge, EX stage): PHT 2-bit counters, global history, valid bits, targets,
//   tag-table write port (ID_EX_btb_index / ID_EX_tag / update_tag), saturating perf counters.
//   Ports:
//     clk, reset (async, active-low)
//     IF_pc, corresponding_tag            -> IF_btb_index, IF_pht_index, predict_taken, predicted_pc
//     EX_is_branch, EX_is_jump, EX_pc, EX_pht_index, EX_taken, EX_target, EX_mispredict
//                                         -> ID_EX_btb_index, ID_EX_tag, update_tag
//     resolved_count, mispredict_count    performance counters
module gshare_branch_predictor #(
    parameter int unsigned BTB_INDEX_WIDTH = 5,
    parameter int unsigned TAG_WIDTH       = 32 - BTB_INDEX_WIDTH - 2,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                IF_pc,
    input  logic [TAG_WIDTH-1:0]       corresponding_tag,
    output logic [BTB_INDEX_WIDTH-1:0] IF_btb_index,
    output logic [BTB_INDEX_WIDTH-1:0] IF_pht_index,
    output logic                       predict_taken,
    output logic [31:0]                predicted_pc,
    input  logic                       EX_is_branch,
    input  logic                       EX_is_jump,
    input  logic [31:0]                EX_pc,
    input  logic [BTB_INDEX_WIDTH-1:0] EX_pht_index,
    input  logic                       EX_taken,
    input  logic [31:0]                EX_target,
    input  logic                       EX_mispredict,
    output logic [BTB_INDEX_WIDTH-1:0] ID_EX_btb_index,
    output logic [TAG_WIDTH-1:0]       ID_EX_tag,
    output logic                       update_tag,
    output logic [CNT_WIDTH-1:0]       resolved_count,
    output logic [CNT_WIDTH-1:0]       mispredict_count
);

    localparam int unsigned Entries = 2 ** BTB_INDEX_WIDTH;

    logic [Entries-1:0]         valid_q;
    logic [31:0]                target_q [Entries];
    logic [1:0]                 pht_q    [Entries];
    logic [BTB_INDEX_WIDTH-1:0] ghr_q;
    logic [CNT_WIDTH-1:0]       resolved_q;
    logic [CNT_WIDTH-1:0]       mispredict_q;

    logic hit;
    logic resolve;

    // Word-offset bits of the PCs carry no prediction information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_pc[1:0], EX_pc[1:0]};

    // Lookup path
    always_comb begin
        IF_btb_index  = IF_pc[BTB_INDEX_WIDTH+1:2];
        IF_pht_index  = IF_btb_index ^ ghr_q;
        hit           = valid_q[IF_btb_index] &&
                        (corresponding_tag == IF_pc[31:BTB_INDEX_WIDTH+2]);
        predict_taken = hit && pht_q[IF_pht_index][1];
        predicted_pc  = predict_taken ? target_q[IF_btb_index] : IF_pc + 32'd4;
    end

    // Tag-table write port: allocate only on taken branches and jumps
    always_comb begin
        ID_EX_btb_index = EX_pc[BTB_INDEX_WIDTH+1:2];
        ID_EX_tag       = EX_pc[31:BTB_INDEX_WIDTH+2];
        update_tag      = EX_is_jump || (EX_is_branch && EX_taken);
        resolve         = EX_is_jump || EX_is_branch;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= '0;
            ghr_q        <= '0;
            resolved_q   <= '0;
            mispredict_q <= '0;
            for (int i = 0; i < Entries; i++) begin
                target_q[i] <= '0;
                pht_q[i]    <= 2'b01;
            end
        end else begin
            // Jump takes priority if both resolution flags are raised.
            if (EX_is_jump) begin
                pht_q[EX_pht_index] <= 2'b11;
            end else if (EX_is_branch) begin
                if (EX_taken && pht_q[EX_pht_index] != 2'b11) begin
                    pht_q[EX_pht_index] <= pht_q[EX_pht_index] + 2'b01;
                end else if (!EX_taken && pht_q[EX_pht_index] != 2'b00) begin
                    pht_q[EX_pht_index] <= pht_q[EX_pht_index] - 2'b01;
                end
                ghr_q <= {ghr_q[BTB_INDEX_WIDTH-2:0], EX_taken};
            end

            if (update_tag) begin
                valid_q[ID_EX_btb_index]  <= 1'b1;
                target_q[ID_EX_btb_index] <= EX_target;
            end

            if (resolve && resolved_q != '1) begin
                resolved_q <= resolved_q + CNT_WIDTH'(1);
            end
            if (EX_mispredict && mispredict_q != '1) begin
                mispredict_q <= mispredict_q + CNT_WIDTH'(1);
            end
        end
    end

    assign resolved_count   = resolved_q;
    assign mispredict_count = mispredict_q;

endmodule
